// File: rtl/ex_mem_stage.sv
// EX->MEM pipeline register: latches ALU result and control, splits SWAP into
// two register writes (stalling upstream one cycle), and squashes on overflow.
module ex_mem_stage #(
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned REG_ADDR_W = 4,
    parameter int unsigned PC_W       = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ex_valid,
    input  logic [2*DATA_W-1:0]   ex_result,
    input  logic                  ex_overflow,
    input  logic                  ex_swap,
    input  logic                  ex_reg_write,
    input  logic                  ex_mem_read,
    input  logic                  ex_mem_write,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic [REG_ADDR_W-1:0] ex_rs,
    input  logic [DATA_W-1:0]     ex_store_data,
    input  logic [PC_W-1:0]       ex_pc,
    input  logic                  flush,
    input  logic                  exc_ack,
    output logic                  stall_out,
    output logic                  mem_valid,
    output logic [DATA_W-1:0]     mem_alu_out,
    output logic [DATA_W-1:0]     mem_store_data,
    output logic [REG_ADDR_W-1:0] mem_wr_addr,
    output logic                  mem_reg_write,
    output logic                  mem_mem_read,
    output logic                  mem_mem_write,
    output logic                  exc_valid,
    output logic [PC_W-1:0]       exc_pc,
    output logic                  exc_sticky
);

    typedef enum logic {RUN, SWAP2} state_t;

    state_t                  state_q, state_d;
    logic                    mem_valid_q, mem_valid_d;
    logic [DATA_W-1:0]       mem_alu_out_q, mem_alu_out_d;
    logic [DATA_W-1:0]       mem_store_data_q, mem_store_data_d;
    logic [REG_ADDR_W-1:0]   mem_wr_addr_q, mem_wr_addr_d;
    logic                    mem_reg_write_q, mem_reg_write_d;
    logic                    mem_mem_read_q, mem_mem_read_d;
    logic                    mem_mem_write_q, mem_mem_write_d;
    logic                    exc_valid_q, exc_valid_d;
    logic [PC_W-1:0]         exc_pc_q, exc_pc_d;
    logic                    exc_sticky_q, exc_sticky_d;
    logic [DATA_W-1:0]       upper_q, upper_d;
    logic [REG_ADDR_W-1:0]   rs_q, rs_d;

    always_comb begin
        state_d          = state_q;
        mem_valid_d      = 1'b0;
        mem_alu_out_d    = mem_alu_out_q;
        mem_store_data_d = mem_store_data_q;
        mem_wr_addr_d    = mem_wr_addr_q;
        mem_reg_write_d  = 1'b0;
        mem_mem_read_d   = 1'b0;
        mem_mem_write_d  = 1'b0;
        exc_valid_d      = 1'b0;
        exc_pc_d         = exc_pc_q;
        exc_sticky_d     = exc_ack ? 1'b0 : exc_sticky_q;
        upper_d          = upper_q;
        rs_d             = rs_q;

        unique case (state_q)
            RUN: begin
                // SWAP is tested before overflow: a SWAP can never raise an exception
                if (ex_valid && !flush) begin
                    if (ex_swap) begin
                        mem_valid_d     = 1'b1;
                        mem_alu_out_d   = ex_result[DATA_W-1:0];
                        mem_wr_addr_d   = ex_rd;
                        mem_reg_write_d = 1'b1;
                        upper_d         = ex_result[2*DATA_W-1:DATA_W];
                        rs_d            = ex_rs;
                        state_d         = SWAP2;
                    end else if (ex_overflow) begin
                        exc_valid_d  = 1'b1;
                        exc_pc_d     = ex_pc;
                        exc_sticky_d = 1'b1;
                    end else begin
                        mem_valid_d      = 1'b1;
                        mem_alu_out_d    = ex_result[DATA_W-1:0];
                        mem_store_data_d = ex_store_data;
                        mem_wr_addr_d    = ex_rd;
                        mem_reg_write_d  = ex_reg_write;
                        mem_mem_read_d   = ex_mem_read;
                        mem_mem_write_d  = ex_mem_write;
                    end
                end
            end
            SWAP2: begin
                // flush is ignored here: the SWAP is committed once its first half is out
                mem_valid_d     = 1'b1;
                mem_alu_out_d   = upper_q;
                mem_wr_addr_d   = rs_q;
                mem_reg_write_d = 1'b1;
                state_d         = RUN;
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q          <= RUN;
            mem_valid_q      <= 1'b0;
            mem_alu_out_q    <= '0;
            mem_store_data_q <= '0;
            mem_wr_addr_q    <= '0;
            mem_reg_write_q  <= 1'b0;
            mem_mem_read_q   <= 1'b0;
            mem_mem_write_q  <= 1'b0;
            exc_valid_q      <= 1'b0;
            exc_pc_q         <= '0;
            exc_sticky_q     <= 1'b0;
            upper_q          <= '0;
            rs_q             <= '0;
        end else begin
            state_q          <= state_d;
            mem_valid_q      <= mem_valid_d;
            mem_alu_out_q    <= mem_alu_out_d;
            mem_store_data_q <= mem_store_data_d;
            mem_wr_addr_q    <= mem_wr_addr_d;
            mem_reg_write_q  <= mem_reg_write_d;
            mem_mem_read_q   <= mem_mem_read_d;
            mem_mem_write_q  <= mem_mem_write_d;
            exc_valid_q      <= exc_valid_d;
            exc_pc_q         <= exc_pc_d;
            exc_sticky_q     <= exc_sticky_d;
            upper_q          <= upper_d;
            rs_q             <= rs_d;
        end
    end

    assign stall_out      = (state_q == SWAP2);
    assign mem_valid      = mem_valid_q;
    assign mem_alu_out    = mem_alu_out_q;
    assign mem_store_data = mem_store_data_q;
    assign mem_wr_addr    = mem_wr_addr_q;
    assign mem_reg_write  = mem_reg_write_q;
    assign mem_mem_read   = mem_mem_read_q;
    assign mem_mem_write  = mem_mem_write_q;
    assign exc_valid      = exc_valid_q;
    assign exc_pc         = exc_pc_q;
    assign exc_sticky     = exc_sticky_q;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Self-checking bench for ex_mem_stage: directed scenarios plus random traffic
// compared against a queue-based reference model.
module tb_ex_mem_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid, ex_overflow, ex_swap, ex_reg_write, ex_mem_read, ex_mem_write;
    logic [31:0] ex_result;
    logic [3:0]  ex_rd, ex_rs;
    logic [15:0] ex_store_data, ex_pc;
    logic        flush, exc_ack;
    logic        stall_out, mem_valid, mem_reg_write, mem_mem_read, mem_mem_write;
    logic [15:0] mem_alu_out, mem_store_data, exc_pc;
    logic [3:0]  mem_wr_addr;
    logic        exc_valid, exc_sticky;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    typedef struct {
        logic [3:0]  addr;
        logic [15:0] data;
    } wr_t;

    wr_t pend[$];

    logic        e_valid, e_rw, e_rd, e_wr, e_exc, e_sticky;
    logic [15:0] e_alu, e_sd, e_pc;
    logic [3:0]  e_addr;

    ex_mem_stage #(.DATA_W(16), .REG_ADDR_W(4), .PC_W(16)) dut (
        .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_result(ex_result),
        .ex_overflow(ex_overflow), .ex_swap(ex_swap), .ex_reg_write(ex_reg_write),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_rd(ex_rd),
        .ex_rs(ex_rs), .ex_store_data(ex_store_data), .ex_pc(ex_pc), .flush(flush),
        .exc_ack(exc_ack), .stall_out(stall_out), .mem_valid(mem_valid),
        .mem_alu_out(mem_alu_out), .mem_store_data(mem_store_data),
        .mem_wr_addr(mem_wr_addr), .mem_reg_write(mem_reg_write),
        .mem_mem_read(mem_mem_read), .mem_mem_write(mem_mem_write),
        .exc_valid(exc_valid), .exc_pc(exc_pc), .exc_sticky(exc_sticky)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        pend.delete();
        {e_valid, e_rw, e_rd, e_wr, e_exc, e_sticky} = '0;
        e_alu = '0; e_sd = '0; e_pc = '0; e_addr = '0;
    endtask

    // Reference: one edge of the stage, from the behavioural rules
    task automatic model_step();
        wr_t w;
        e_exc = 1'b0;
        if (exc_ack) e_sticky = 1'b0;
        e_valid = 1'b0; e_rw = 1'b0; e_rd = 1'b0; e_wr = 1'b0;
        if (pend.size() != 0) begin
            w = pend.pop_front();
            e_valid = 1'b1; e_rw = 1'b1; e_alu = w.data; e_addr = w.addr;
        end else if (ex_valid && !flush) begin
            if (ex_swap) begin
                e_valid = 1'b1; e_rw = 1'b1; e_alu = ex_result[15:0]; e_addr = ex_rd;
                w.addr = ex_rs; w.data = ex_result[31:16];
                pend.push_back(w);
            end else if (ex_overflow) begin
                e_exc = 1'b1; e_pc = ex_pc; e_sticky = 1'b1;
            end else begin
                e_valid = 1'b1; e_rw = ex_reg_write; e_rd = ex_mem_read; e_wr = ex_mem_write;
                e_alu = ex_result[15:0]; e_addr = ex_rd; e_sd = ex_store_data;
            end
        end
    endtask

    task automatic check_outputs();
        chk("mem_valid", 32'(mem_valid), 32'(e_valid));
        chk("mem_reg_write", 32'(mem_reg_write), 32'(e_rw));
        chk("mem_mem_read", 32'(mem_mem_read), 32'(e_rd));
        chk("mem_mem_write", 32'(mem_mem_write), 32'(e_wr));
        chk("exc_valid", 32'(exc_valid), 32'(e_exc));
        chk("exc_sticky", 32'(exc_sticky), 32'(e_sticky));
        chk("exc_pc", 32'(exc_pc), 32'(e_pc));
        if (e_valid) begin
            chk("mem_alu_out", 32'(mem_alu_out), 32'(e_alu));
            chk("mem_wr_addr", 32'(mem_wr_addr), 32'(e_addr));
            if (e_wr) chk("mem_store_data", 32'(mem_store_data), 32'(e_sd));
        end
    endtask

    // Called at a negedge: drive inputs, let one posedge pass, check at next negedge
    task automatic apply(input logic v, input logic [31:0] res, input logic ovf,
                         input logic sw, input logic rw, input logic rd, input logic wr,
                         input logic [3:0] rdst, input logic [3:0] rsrc,
                         input logic [15:0] sd, input logic [15:0] pc,
                         input logic fl, input logic ack);
        chk("stall_out", 32'(stall_out), 32'(pend.size() != 0));
        ex_valid = v; ex_result = res; ex_overflow = ovf; ex_swap = sw;
        ex_reg_write = rw; ex_mem_read = rd; ex_mem_write = wr; ex_rd = rdst;
        ex_rs = rsrc; ex_store_data = sd; ex_pc = pc; flush = fl; exc_ack = ack;
        model_step();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic idle();
        apply(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0, '0, 1'b0, 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        {ex_valid, ex_overflow, ex_swap, ex_reg_write, ex_mem_read, ex_mem_write, flush, exc_ack} = '0;
        ex_result = '0; ex_rd = '0; ex_rs = '0; ex_store_data = '0; ex_pc = '0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("reset_stall", 32'(stall_out), 32'd0);
        check_outputs();
        rst = 1'b0;

        // ADD
        apply(1'b1, 32'h0000_1234, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd3, 4'd0, 16'h0, 16'h10, 1'b0, 1'b0);
        // SWAP, then an ADD held upstream during SWAP2 and re-presented
        apply(1'b1, 32'hAAAA_5555, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd2, 4'd7, 16'h0, 16'h12, 1'b0, 1'b0);
        chk("swap_first_alu", 32'(mem_alu_out), 32'h5555);
        apply(1'b1, 32'h0000_0042, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd5, 4'd0, 16'h0, 16'h14, 1'b0, 1'b0);
        chk("swap_second_alu", 32'(mem_alu_out), 32'hAAAA);
        chk("swap_second_addr", 32'(mem_wr_addr), 32'd7);
        apply(1'b1, 32'h0000_0042, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd5, 4'd0, 16'h0, 16'h14, 1'b0, 1'b0);
        // Overflow, then sticky holds, then flush+overflow, then ack
        apply(1'b1, 32'h1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd1, 4'd0, 16'h0, 16'h0040, 1'b0, 1'b0);
        idle();
        apply(1'b1, 32'h1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd1, 4'd0, 16'h0, 16'h0099, 1'b1, 1'b0);
        apply(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0, '0, 1'b0, 1'b1);
        // Ack and new overflow together: set wins
        apply(1'b1, 32'h1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd1, 4'd0, 16'h0, 16'h0050, 1'b0, 1'b1);
        // Store and load
        apply(1'b1, 32'h0000_0100, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 4'd0, 16'hBEEF, 16'h52, 1'b0, 1'b1);
        apply(1'b1, 32'h0000_0104, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd9, 4'd0, 16'h0, 16'h54, 1'b0, 1'b0);
        // Flush during SWAP2 does not cancel the upper write
        apply(1'b1, 32'h1111_2222, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd4, 4'd6, 16'h0, 16'h56, 1'b0, 1'b0);
        apply(1'b1, 32'h0000_0077, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd8, 4'd0, 16'h0, 16'h58, 1'b1, 1'b0);
        chk("flush_swap2_alu", 32'(mem_alu_out), 32'h1111);

        // Async reset in SWAP2
        apply(1'b1, 32'hCAFE_F00D, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd1, 4'd2, 16'h0, 16'h60, 1'b0, 1'b0);
        #1 rst = 1'b1;
        #1;
        model_reset();
        chk("rst_async_stall", 32'(stall_out), 32'd0);
        check_outputs();
        @(negedge clk);
        rst = 1'b0;
        apply(1'b1, 32'h0102_0304, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd10, 4'd11, 16'h0, 16'h62, 1'b0, 1'b0);
        apply(1'b1, 32'h0506_0708, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd12, 4'd13, 16'h0, 16'h64, 1'b0, 1'b0);
        apply(1'b1, 32'h0506_0708, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd12, 4'd13, 16'h0, 16'h64, 1'b0, 1'b0);
        idle();
        idle();

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            apply(($urandom_range(0, 9) < 8), $urandom(), ($urandom_range(0, 6) == 0),
                  ($urandom_range(0, 3) == 0), 1'($urandom()), 1'($urandom()), 1'($urandom()),
                  4'($urandom()), 4'($urandom()), 16'($urandom()), 16'($urandom()),
                  ($urandom_range(0, 6) == 0), ($urandom_range(0, 4) == 0));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
